// File: rtl/periph_apb_arb_pkg.sv
// Shared types and constants for the peripheral APB arbiter.
// Imported by the round-robin picker and the arbiter top.
package periph_apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } arb_state_e;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/periph_rr_arbiter.sv
// Combinational round-robin picker: first request at or after
// the pointer, wrapping modulo NB_REQ.
module periph_rr_arbiter
    import periph_apb_arb_pkg::*;
#(
    parameter int NB_REQ = 2,
    parameter int IDX_W  = idx_w(NB_REQ)
) (
    input  logic [NB_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic [NB_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]  o_idx
);

    logic             w_found;
    logic [IDX_W-1:0] w_j;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = '0;
        for (int k = 0; k < NB_REQ; k++) begin
            w_j = IDX_W'((int'(i_ptr) + k) % NB_REQ);
            if (!w_found && i_req[w_j]) begin
                w_found    = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_idx      = w_j;
            end
        end
    end

endmodule

// File: rtl/periph_apb_arbiter.sv
// Round-robin APB arbiter: N requesters share one downstream slave
// port, one transfer in flight, bounded ACCESS with forced error.
module periph_apb_arbiter
    import periph_apb_arb_pkg::*;
#(
    parameter int NB_REQ         = 2,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NB_REQ-1:0]                      req_psel_i,
    input  logic [NB_REQ-1:0]                      req_penable_i,
    input  logic [NB_REQ-1:0]                      req_pwrite_i,
    input  logic [NB_REQ-1:0][APB_ADDR_WIDTH-1:0]  req_paddr_i,
    input  logic [NB_REQ-1:0][APB_DATA_WIDTH-1:0]  req_pwdata_i,
    output logic [NB_REQ-1:0][APB_DATA_WIDTH-1:0]  req_prdata_o,
    output logic [NB_REQ-1:0]                      req_pready_o,
    output logic [NB_REQ-1:0]                      req_pslverr_o,
    output logic                                   m_psel_o,
    output logic                                   m_penable_o,
    output logic                                   m_pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0]              m_paddr_o,
    output logic [APB_DATA_WIDTH-1:0]              m_pwdata_o,
    input  logic [APB_DATA_WIDTH-1:0]              m_prdata_i,
    input  logic                                   m_pready_i,
    input  logic                                   m_pslverr_i,
    output logic [NB_REQ-1:0]                      grant_o,
    output logic                                   timeout_o
);

    localparam int IW      = idx_w(NB_REQ);
    localparam int CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    arb_state_e                r_state;
    arb_state_e                w_state_nxt;
    logic [IW-1:0]             r_ptr;
    logic [IW-1:0]             r_gidx;
    logic [NB_REQ-1:0]         r_grant;
    logic [APB_ADDR_WIDTH-1:0] r_addr;
    logic [APB_DATA_WIDTH-1:0] r_wdata;
    logic                      r_write;
    logic [CW-1:0]             r_cnt;
    logic [NB_REQ-1:0]         w_arb_gnt;
    logic [IW-1:0]             w_arb_idx;
    logic                      w_access;
    logic                      w_start;
    logic                      w_timeout;
    logic                      w_done;

    periph_rr_arbiter #(
        .NB_REQ (NB_REQ),
        .IDX_W  (IW)
    ) u_rr (
        .i_req  (req_psel_i),
        .i_ptr  (r_ptr),
        .o_gnt  (w_arb_gnt),
        .o_idx  (w_arb_idx)
    );

    assign w_access  = (r_state == ST_ACCESS);
    assign w_start   = (r_state == ST_IDLE) && (|req_psel_i);
    // A slave answering on the last allowed cycle still wins.
    assign w_timeout = (TIMEOUT_CYCLES > 0) && w_access && !m_pready_i
                       && (r_cnt == CW'(TO_LAST));
    assign w_done    = w_access && (m_pready_i || w_timeout);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_start) w_state_nxt = ST_SETUP;
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (w_done) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr   <= '0;
            r_gidx  <= '0;
            r_grant <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_start) begin
                r_grant <= w_arb_gnt;
                r_gidx  <= w_arb_idx;
                r_addr  <= req_paddr_i[w_arb_idx];
                r_wdata <= req_pwdata_i[w_arb_idx];
                r_write <= req_pwrite_i[w_arb_idx];
            end
            if (w_done) begin
                r_grant <= '0;
                r_ptr   <= (r_gidx == IW'(NB_REQ - 1)) ? '0 : r_gidx + 1'b1;
            end
            if (!w_access) begin
                r_cnt <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Normal responses are gated by the owner's PENABLE; forced ones are not.
    always_comb begin
        req_pready_o  = '0;
        req_pslverr_o = '0;
        req_prdata_o  = '0;
        if (w_access && m_pready_i && req_penable_i[r_gidx]) begin
            req_pready_o[r_gidx]  = 1'b1;
            req_pslverr_o[r_gidx] = m_pslverr_i;
            req_prdata_o[r_gidx]  = m_prdata_i;
        end else if (w_timeout) begin
            req_pready_o[r_gidx]  = 1'b1;
            req_pslverr_o[r_gidx] = 1'b1;
            req_prdata_o[r_gidx]  = APB_DATA_WIDTH'(TIMEOUT_RDATA);
        end
    end

    assign m_psel_o    = (r_state != ST_IDLE);
    assign m_penable_o = w_access;
    assign m_pwrite_o  = r_write;
    assign m_paddr_o   = r_addr;
    assign m_pwdata_o  = r_wdata;
    assign grant_o     = r_grant;
    assign timeout_o   = w_timeout;

endmodule
